// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: VGA raster prefetch into a small FWFT FIFO shares one
// single-port synchronous RAM with a CPU pixel-write port, one memory op per cycle.
module vga_fb_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 2,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_frame_start,
  input  logic              disp_pop,
  output logic [23:0]       disp_data,
  output logic              disp_empty,
  output logic              disp_underflow,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [9:0]        cpu_wr_h,
  input  logic [9:0]        cpu_wr_v,
  input  logic [23:0]       cpu_wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LOW_WM_C = CNT_W'(LOW_WM);
  localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);
  localparam logic [9:0]       H_LAST   = 10'(H_RES - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_RES - 1);
  localparam logic [9:0]       H_LIM    = 10'(H_RES);
  localparam logic [9:0]       V_LIM    = 10'(V_RES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0] count_r, level_s, after_pop_s;
  logic             inflight_r;
  logic [9:0]       fetch_h_r, fetch_v_r;
  logic [23:0]      fifo_r [FIFO_DEPTH];
  logic [23:0]      disp_data_r;
  logic             disp_underflow_r;

  logic fetch_elig_s, fetch_grant_s, cpu_grant_s, cpu_in_range_s;
  logic push_s, pop_s, last_pix_s;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] h, input logic [9:0] v);
    return ADDR_W'(32'(v) * 32'(H_RES) + 32'(h));
  endfunction

  assign level_s     = count_r + CNT_W'(inflight_r);
  // A read return arriving in the restart cycle belongs to the old frame and is dropped.
  assign push_s      = inflight_r && !disp_frame_start;
  assign pop_s       = disp_pop && (count_r != ZERO_C) && !disp_frame_start;
  assign after_pop_s = count_r - CNT_W'(pop_s);
  assign last_pix_s  = (fetch_h_r == H_LAST) && (fetch_v_r == V_LAST);

  assign disp_data      = disp_data_r;
  assign disp_empty     = (count_r == ZERO_C);
  assign disp_underflow = disp_underflow_r;

  // Arbitration: low-level display fetch, then CPU write, then opportunistic fetch.
  always_comb begin
    fetch_grant_s  = 1'b0;
    cpu_grant_s    = 1'b0;
    cpu_in_range_s = (cpu_wr_h < H_LIM) && (cpu_wr_v < V_LIM);
    fetch_elig_s   = (state_r == FETCH) && (level_s < DEPTH_C) &&
                     !disp_frame_start && !reset;
    if (fetch_elig_s && (level_s <= LOW_WM_C)) begin
      fetch_grant_s = 1'b1;
    end else if (cpu_wr_valid && !reset) begin
      cpu_grant_s = 1'b1;
    end else if (fetch_elig_s) begin
      fetch_grant_s = 1'b1;
    end else begin
      fetch_grant_s = 1'b0;
      cpu_grant_s   = 1'b0;
    end
  end

  // Memory port drive for the winning master; out-of-range CPU writes are swallowed.
  always_comb begin
    cpu_wr_ready = cpu_grant_s;
    mem_we       = cpu_grant_s && cpu_in_range_s;
    mem_en       = fetch_grant_s || mem_we;
    mem_wdata    = 24'd0;
    mem_addr     = {ADDR_W{1'b0}};
    if (fetch_grant_s) begin
      mem_addr = pix_addr(fetch_h_r, fetch_v_r);
    end else if (mem_we) begin
      mem_addr  = pix_addr(cpu_wr_h, cpu_wr_v);
      mem_wdata = cpu_wr_data;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 24'd0;
    end
  end

  // Fetch FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (disp_frame_start) state_s = FETCH;
        else                  state_s = IDLE;
      end
      FETCH: begin
        if (disp_frame_start)                 state_s = FETCH;
        else if (fetch_grant_s && last_pix_s) state_s = DONE;
        else                                  state_s = FETCH;
      end
      DONE: begin
        if (disp_frame_start) state_s = FETCH;
        else                  state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Raster fetch position, advanced on every issued display read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_h_r <= 10'd0;
      fetch_v_r <= 10'd0;
    end else if (disp_frame_start) begin
      fetch_h_r <= 10'd0;
      fetch_v_r <= 10'd0;
    end else if (fetch_grant_s) begin
      if (fetch_h_r == H_LAST) begin
        fetch_h_r <= 10'd0;
        fetch_v_r <= (fetch_v_r == V_LAST) ? 10'd0 : fetch_v_r + 10'd1;
      end else begin
        fetch_h_r <= fetch_h_r + 10'd1;
      end
    end else begin
      fetch_h_r <= fetch_h_r;
      fetch_v_r <= fetch_v_r;
    end
  end

  // Prefetch FIFO, in-flight read tracking and sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r         <= PTR_W'(0);
      wr_ptr_r         <= PTR_W'(0);
      count_r          <= ZERO_C;
      inflight_r       <= 1'b0;
      disp_data_r      <= 24'd0;
      disp_underflow_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= 24'd0;
    end else begin
      inflight_r <= fetch_grant_s;
      if (disp_pop && (count_r == ZERO_C) && !disp_frame_start) disp_underflow_r <= 1'b1;
      if (disp_frame_start) begin
        rd_ptr_r <= PTR_W'(0);
        wr_ptr_r <= PTR_W'(0);
        count_r  <= ZERO_C;
      end else begin
        if (push_s) begin
          fifo_r[wr_ptr_r] <= mem_rdata;
          wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        // Head register: next stored entry, or the word arriving into an emptied FIFO.
        if (after_pop_s != ZERO_C)
          disp_data_r <= fifo_r[rd_ptr_r + PTR_W'(pop_s)];
        else if (push_s)
          disp_data_r <= mem_rdata;
        else
          disp_data_r <= disp_data_r;
      end
    end
  end

endmodule
